// File: rtl/register_general_write_controller.sv
// Write-port sequencer/arbiter for the GPR file: merges byte/word writes, runs the 8-beat block write.
// Define ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module register_general_write_controller (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [2:0]   req0_index_i,
    input  logic [1:0]   req0_size_i,
    input  logic [31:0]  req0_data_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [2:0]   req1_index_i,
    input  logic [1:0]   req1_size_i,
    input  logic [31:0]  req1_data_i,
    input  logic         req1_block_i,
    input  logic [255:0] gpr_value_i,
    output logic         write_enable_o,
    output logic [2:0]   write_index_o,
    output logic [31:0]  write_data_o,
    output logic         block_busy_o
);

    typedef enum logic [0:0] {StIdle, StBlock} state_e;

    state_e      state_q;
    logic [2:0]  beat_q;
    logic        live_q;
    logic        we_q;
    logic [2:0]  widx_q;
    logic [31:0] wdata_q;
    logic        busy_q;

    logic        win0;
    logic        in_idle;
    logic        in_block;
    logic        acc0;
    logic        acc1;
    logic        block_beat;
    logic [2:0]  beat_idx;
    logic [2:0]  sel_index;
    logic [1:0]  sel_size;
    logic [31:0] sel_data;
    logic [2:0]  tgt;
    logic [31:0] base;
    logic [31:0] merged;
    logic        wr_valid;

`ifdef ROUND_ROBIN_EN
    logic prio0_q;
    assign win0 = prio0_q;
`else
    assign win0 = 1'b1;
`endif

    // Block write order: EDI, ESI, EBP, ESP (discarded), EBX, EDX, ECX, EAX
    function automatic logic [2:0] block_reg(input logic [2:0] beat);
        case (beat)
            3'd0:    block_reg = 3'd5;
            3'd1:    block_reg = 3'd4;
            3'd2:    block_reg = 3'd6;
            3'd3:    block_reg = 3'd7;
            3'd4:    block_reg = 3'd1;
            3'd5:    block_reg = 3'd3;
            3'd6:    block_reg = 3'd2;
            default: block_reg = 3'd0;
        endcase
    endfunction

    always_comb begin
        in_idle      = live_q && (state_q == StIdle);
        in_block     = live_q && (state_q == StBlock);
        req0_ready_o = reset && in_idle && (!req1_valid_i || win0);
        req1_ready_o = reset && (in_block || (in_idle && (!req0_valid_i || !win0)));
        acc0         = req0_valid_i && req0_ready_o;
        acc1         = req1_valid_i && req1_ready_o;
        block_beat   = acc1 && (in_block || req1_block_i);
        beat_idx     = in_block ? beat_q : 3'd0;

        if (acc0) begin
            sel_index = req0_index_i;
            sel_size  = req0_size_i;
            sel_data  = req0_data_i;
        end else begin
            sel_index = req1_index_i;
            sel_size  = req1_size_i;
            sel_data  = req1_data_i;
        end
        if (block_beat) begin
            sel_index = block_reg(beat_idx);
            sel_size  = 2'b10;
        end

        // Byte indices 4-7 address AH..DH, i.e. the high byte of registers 0-3
        tgt  = (sel_size == 2'b00) ? {1'b0, sel_index[1:0]} : sel_index;
        base = (we_q && (widx_q == tgt)) ? wdata_q : gpr_value_i[{tgt, 5'd0} +: 32];

        case (sel_size)
            2'b00: merged = sel_index[2] ? {base[31:16], sel_data[7:0], base[7:0]}
                                         : {base[31:8], sel_data[7:0]};
            2'b01: merged = {base[31:16], sel_data[15:0]};
            default: merged = sel_data;
        endcase

        wr_valid = (acc0 || acc1) && !(block_beat && (beat_idx == 3'd3));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            beat_q  <= 3'd0;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            widx_q  <= 3'd0;
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
            prio0_q <= 1'b1;
`endif
        end else begin
            live_q <= 1'b1;
            we_q   <= wr_valid;
            if (wr_valid) begin
                widx_q  <= tgt;
                wdata_q <= merged;
            end
`ifdef ROUND_ROBIN_EN
            if (in_idle && (acc0 || acc1)) begin
                prio0_q <= acc1;
            end
`endif
            case (state_q)
                StIdle: begin
                    if (in_idle && acc1 && req1_block_i) begin
                        state_q <= StBlock;
                        beat_q  <= 3'd1;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (acc1) begin
                        if (beat_q == 3'd7) begin
                            state_q <= StIdle;
                            beat_q  <= 3'd0;
                            busy_q  <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign write_enable_o = we_q;
    assign write_index_o  = widx_q;
    assign write_data_o   = wdata_q;
    assign block_busy_o   = busy_q;

endmodule

// File: tb/tb_register_general_write_controller.sv
// Self-checking bench for register_general_write_controller: vector table plus
// contention, block and reset-mid-block sequences.
module tb_register_general_write_controller;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SW = 2'b01;
    localparam logic [1:0] SD = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    logic         clock;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready, req1_block;
    logic [2:0]   req0_index, req1_index;
    logic [1:0]   req0_size, req1_size;
    logic [31:0]  req0_data, req1_data;
    logic [255:0] gpr_value;
    logic         write_enable, block_busy;
    logic [2:0]   write_index;
    logic [31:0]  write_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic v0; logic [2:0] i0; logic [1:0] s0; logic [31:0] d0;
        logic v1; logic blk; logic [2:0] i1; logic [1:0] s1; logic [31:0] d1;
        logic er0; logic er1; logic ewe; logic [2:0] eidx; logic [31:0] edata; logic ebusy;
    } vec_t;

    typedef struct {
        logic we; logic [2:0] idx; logic [31:0] data; logic busy;
    } exp_t;

    exp_t sbq[$];

    register_general_write_controller dut (
        .clock          (clock),
        .reset          (reset),
        .req0_valid_i   (req0_valid),
        .req0_ready_o   (req0_ready),
        .req0_index_i   (req0_index),
        .req0_size_i    (req0_size),
        .req0_data_i    (req0_data),
        .req1_valid_i   (req1_valid),
        .req1_ready_o   (req1_ready),
        .req1_index_i   (req1_index),
        .req1_size_i    (req1_size),
        .req1_data_i    (req1_data),
        .req1_block_i   (req1_block),
        .gpr_value_i    (gpr_value),
        .write_enable_o (write_enable),
        .write_index_o  (write_index),
        .write_data_o   (write_data),
        .block_busy_o   (block_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v0, input logic [2:0] i0, input logic [1:0] s0, input logic [31:0] d0,
        input logic v1, input logic blk, input logic [2:0] i1, input logic [1:0] s1,
        input logic [31:0] d1, input logic er0, input logic er1, input logic ewe,
        input logic [2:0] eidx, input logic [31:0] edata, input logic ebusy);
        vec_t v;
        v.v0 = v0; v.i0 = i0; v.s0 = s0; v.d0 = d0;
        v.v1 = v1; v.blk = blk; v.i1 = i1; v.s1 = s1; v.d1 = d1;
        v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.eidx = eidx; v.edata = edata;
        v.ebusy = ebusy;
        return v;
    endfunction

    // Drive one cycle of stimulus; expected write is queued now, compared after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        req0_valid = v.v0; req0_index = v.i0; req0_size = v.s0; req0_data = v.d0;
        req1_valid = v.v1; req1_block = v.blk; req1_index = v.i1; req1_size = v.s1;
        req1_data  = v.d1;
        e.we = v.ewe; e.idx = v.eidx; e.data = v.edata; e.busy = v.ebusy;
        sbq.push_back(e);
        #3;
        if (v.v0) check({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, v.er0});
        if (v.v1) check({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, v.er1});
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check({tag, "_we"}, {31'd0, write_enable}, {31'd0, e.we});
        if (e.we) begin
            check({tag, "_idx"}, {29'd0, write_index}, {29'd0, e.idx});
            check({tag, "_data"}, write_data, e.data);
        end
        check({tag, "_busy"}, {31'd0, block_busy}, {31'd0, e.busy});
    endtask

    vec_t tbl[12];
    vec_t v;
    int   g;

    initial begin
        gpr_value = {32'hFFFF0000, 32'h66666666, 32'h55555555, 32'h44444444,
                     32'h33333333, 32'h22220000, 32'hA1A1A1A1, 32'h11223344};
        reset = 1'b0;
        req0_valid = 1'b1; req0_index = 3'd0; req0_size = SD; req0_data = 32'h01010101;
        req1_valid = 1'b1; req1_block = 1'b0; req1_index = 3'd1; req1_size = SD;
        req1_data  = 32'h02020202;

        #7;
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_idx", {29'd0, write_index}, 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_busy", {31'd0, block_busy}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        reset = 1'b1;

        // First cycle after release accepts nothing
        apply(mk(1, 0, SD, 32'h01010101, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0), "rel");

        tbl[0]  = mk(1, 4, SB, 32'h000000AB, 0, 0, 0, SD, 0, 1, 0, 1, 0, 32'h1122AB44, 0);
        tbl[1]  = mk(0, 0, SD, 0, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, SD, 32'hDEADBEEF, 0, 0, 0, SD, 0, 1, 0, 1, 2, 32'hDEADBEEF, 0);
        tbl[3]  = mk(1, 2, SW, 32'h00001234, 0, 0, 0, SD, 0, 1, 0, 1, 2, 32'hDEAD1234, 0);
        tbl[4]  = mk(1, 2, SB, 32'h00000055, 0, 0, 0, SD, 0, 1, 0, 1, 2, 32'hDEAD1255, 0);
        tbl[5]  = mk(0, 0, SD, 0, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, SD, 0, 1, 0, 7, SW, 32'h000000AA, 0, 1, 1, 7, 32'hFFFF00AA, 0);
        tbl[7]  = mk(0, 0, SD, 0, 1, 0, 7, SB, 32'h000000C3, 0, 1, 1, 3, 32'h3333C333, 0);
        tbl[8]  = mk(1, 3, SX, 32'h0BADF00D, 0, 0, 0, SD, 0, 1, 0, 1, 3, 32'h0BADF00D, 0);
        tbl[9]  = mk(0, 0, SD, 0, 1, 0, 3, SB, 32'h0000007E, 0, 1, 1, 3, 32'h0BADF07E, 0);
        tbl[10] = mk(0, 0, SD, 0, 1, 0, 1, SB, 32'h00000099, 0, 1, 1, 1, 32'hA1A1A199, 0);
        tbl[11] = mk(0, 0, SD, 0, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Contention held four cycles; last idle grant was port 1
        for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
            g = k % 2;
`else
            g = 0;
`endif
            v = mk(1, 4, SD, 32'h40404040, 1, 0, 5, SD, 32'h50505050,
                   (g == 0), (g == 1), 1, (g == 0) ? 3'd4 : 3'd5,
                   (g == 0) ? 32'h40404040 : 32'h50505050, 0);
            apply(v, $sformatf("cont%0d", k));
        end

        // Block sequence with req0 pending (must stay blocked) and one gap after beat 3
        apply(mk(0, 0, SD, 0, 1, 1, 3, SB, 32'h10, 0, 1, 1, 5, 32'h10, 1), "blk0");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h11, 0, 1, 1, 4, 32'h11, 1), "blk1");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 0, 3, SB, 32'h12, 0, 1, 1, 6, 32'h12, 1), "blk2");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h13, 0, 1, 0, 0, 0, 1), "blk3");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 0, 0, 3, SB, 32'h99, 0, 0, 0, 0, 0, 1), "blkgap");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h14, 0, 1, 1, 1, 32'h14, 1), "blk4");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h15, 0, 1, 1, 3, 32'h15, 1), "blk5");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h16, 0, 1, 1, 2, 32'h16, 1), "blk6");
        apply(mk(1, 0, SD, 32'hEEEEEEEE, 1, 1, 3, SB, 32'h17, 0, 1, 1, 0, 32'h17, 0), "blk7");
        apply(mk(0, 0, SD, 0, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0), "post");

        // Reset in the middle of a block sequence
        apply(mk(0, 0, SD, 0, 1, 1, 0, SD, 32'h20, 0, 1, 1, 5, 32'h20, 1), "rb0");
        apply(mk(0, 0, SD, 0, 1, 1, 0, SD, 32'h21, 0, 1, 1, 4, 32'h21, 1), "rb1");
        apply(mk(0, 0, SD, 0, 1, 1, 0, SD, 32'h22, 0, 1, 1, 6, 32'h22, 1), "rb2");
        req0_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, write_enable}, 32'd0);
        check("mid_rst_idx", {29'd0, write_index}, 32'd0);
        check("mid_rst_data", write_data, 32'd0);
        check("mid_rst_busy", {31'd0, block_busy}, 32'd0);
        check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clock);
        #1;
        check("mid_rst_hold_we", {31'd0, write_enable}, 32'd0);
        reset = 1'b1;
        apply(mk(1, 6, SD, 32'hCAFEF00D, 0, 0, 0, SD, 0, 0, 0, 0, 0, 0, 0), "rr_rel");
        apply(mk(1, 6, SD, 32'hCAFEF00D, 0, 0, 0, SD, 0, 1, 0, 1, 6, 32'hCAFEF00D, 0), "rr_w0");
        apply(mk(0, 0, SD, 0, 1, 0, 1, SD, 32'h12345678, 0, 1, 1, 1, 32'h12345678, 0), "rr_w1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
